// File: rtl/pw_group_serializer.sv
// Channel-group serializer: latches one IN_CHANNEL-wide vector per frame and
// streams it out as GROUP_CHANNEL-wide groups under valid/ready on both sides.
module pw_group_serializer #(
    parameter int DATA_WIDTH    = 8,
    parameter int IN_CHANNEL    = 18,
    parameter int GROUP_CHANNEL = 9,
    parameter int NUM_GROUP     = (IN_CHANNEL + GROUP_CHANNEL - 1) / GROUP_CHANNEL,
    parameter int GRP_W         = (NUM_GROUP > 1) ? $clog2(NUM_GROUP) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH*IN_CHANNEL-1:0]    data_in,
    input  logic [GRP_W:0]                      cfg_groups,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH*GROUP_CHANNEL-1:0] data_out,
    output logic [GRP_W-1:0]                    out_grp,
    output logic                                out_last
);
    localparam int IN_W  = DATA_WIDTH * IN_CHANNEL;
    localparam int GW    = DATA_WIDTH * GROUP_CHANNEL;
    localparam int PAD_W = GW * NUM_GROUP;
    localparam logic [GRP_W:0] NG  = (GRP_W+1)'(NUM_GROUP);
    localparam logic [GRP_W:0] ONE = (GRP_W+1)'(1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  buf_q, buf_d;
    logic [GRP_W:0]   ngrp_q, ngrp_d;
    logic [GRP_W-1:0] grp_q, grp_d;

    logic [GRP_W:0]   cfg_clamped;
    logic             is_last;
    logic             load;
    logic [NUM_GROUP-1:0][GW-1:0] grp_arr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            ngrp_q  <= ONE;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            ngrp_q  <= ngrp_d;
            grp_q   <= grp_d;
        end
    end

    always_comb begin
        cfg_clamped = cfg_groups;
        if (cfg_groups == '0)
            cfg_clamped = ONE;
        else if (cfg_groups > NG)
            cfg_clamped = NG;
    end

    assign is_last = ({1'b0, grp_q} == (ngrp_q - ONE));

    // Tail of the last group is padding and must read as zero.
    assign grp_arr = PAD_W'(buf_q);

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        ngrp_d    = ngrp_q;
        grp_d     = grp_q;
        out_valid = 1'b0;
        in_ready  = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                load     = in_valid;
                if (in_valid) state_d = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                in_ready  = is_last && out_ready;
                if (out_ready) begin
                    if (!is_last)
                        grp_d = grp_q + GRP_W'(1);
                    else if (in_valid)
                        load = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            buf_d  = data_in;
            ngrp_d = cfg_clamped;
            grp_d  = '0;
        end
    end

    assign data_out = grp_arr[grp_q];
    assign out_grp  = grp_q;
    assign out_last = out_valid && is_last;
endmodule

// File: tb/tb_pw_group_serializer.sv
// Directed bench: default 18/9 instance plus a padded 20/8 instance.
module tb_pw_group_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: 18 channels, groups of 9 (NUM_GROUP=2, GRP_W=1)
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [143:0] a_data_in;
    logic [1:0]   a_cfg;
    logic [71:0]  a_data_out;
    logic [0:0]   a_out_grp;

    // Instance B: 20 channels, groups of 8 (NUM_GROUP=3, GRP_W=2)
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [159:0] b_data_in;
    logic [2:0]   b_cfg;
    logic [63:0]  b_data_out;
    logic [1:0]   b_out_grp;

    pw_group_serializer dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .data_in(a_data_in), .cfg_groups(a_cfg), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .data_out(a_data_out), .out_grp(a_out_grp),
        .out_last(a_out_last)
    );

    pw_group_serializer #(.DATA_WIDTH(8), .IN_CHANNEL(20), .GROUP_CHANNEL(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .data_in(b_data_in), .cfg_groups(b_cfg), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .data_out(b_data_out), .out_grp(b_out_grp),
        .out_last(b_out_last)
    );

    // channel c carries base+c
    function automatic logic [143:0] vec_a(int base);
        logic [143:0] v;
        for (int c = 0; c < 18; c++) v[c*8 +: 8] = 8'(base + c);
        return v;
    endfunction

    function automatic logic [71:0] grp_a(int base, int g);
        logic [71:0] v;
        for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(base + g*9 + k);
        return v;
    endfunction

    function automatic logic [159:0] vec_b(int base);
        logic [159:0] v;
        for (int c = 0; c < 20; c++) v[c*8 +: 8] = 8'(base + c);
        return v;
    endfunction

    function automatic logic [63:0] grp_b(int base, int g);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = (g*8 + k < 20) ? 8'(base + g*8 + k) : 8'd0;
        return v;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", a_out_valid); end
        n_tests++; if (a_data_out !== 72'd0) begin n_fail++; $display("FAIL reset_data got %h exp 0", a_data_out); end
        n_tests++; if (a_out_grp !== 1'b0 || a_out_last !== 1'b0) begin n_fail++; $display("FAIL reset_grp_last got %b/%b exp 0/0", a_out_grp, a_out_last); end
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
        n_tests++; if (b_out_valid !== 1'b0 || b_data_out !== 64'd0) begin n_fail++; $display("FAIL reset_b got %b/%h exp 0/0", b_out_valid, b_data_out); end
    endtask

    task automatic test_basic();
        @(negedge clk);
        a_in_valid = 1'b1; a_data_in = vec_a(1); a_cfg = 2'd2; a_out_ready = 1'b1; #1;
        n_tests++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle got rdy=%b vld=%b exp 1/0", a_in_ready, a_out_valid); end
        @(negedge clk);
        a_in_valid = 1'b0; #1;
        n_tests++; if (a_out_valid !== 1'b1 || a_data_out !== grp_a(1, 0)) begin n_fail++; $display("FAIL basic_g0 got %b/%h exp 1/%h", a_out_valid, a_data_out, grp_a(1, 0)); end
        n_tests++; if (a_out_grp !== 1'b0 || a_out_last !== 1'b0 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_g0_ctl got grp=%b last=%b rdy=%b exp 0/0/0", a_out_grp, a_out_last, a_in_ready); end
        @(negedge clk); #1;
        n_tests++; if (a_data_out !== grp_a(1, 1)) begin n_fail++; $display("FAIL basic_g1 got %h exp %h", a_data_out, grp_a(1, 1)); end
        n_tests++; if (a_out_grp !== 1'b1 || a_out_last !== 1'b1 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_g1_ctl got grp=%b last=%b rdy=%b exp 1/1/1", a_out_grp, a_out_last, a_in_ready); end
        @(negedge clk); #1;
        n_tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_end got vld=%b rdy=%b exp 0/1", a_out_valid, a_in_ready); end
    endtask

    task automatic test_padding();
        @(negedge clk);
        b_in_valid = 1'b1; b_data_in = vec_b(1); b_cfg = 3'd3; b_out_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            b_in_valid = 1'b0; #1;
            n_tests++; if (b_out_valid !== 1'b1 || b_out_grp !== 2'(g) || b_data_out !== grp_b(1, g)) begin n_fail++; $display("FAIL pad_g%0d got vld=%b grp=%0d data=%h exp 1/%0d/%h", g, b_out_valid, b_out_grp, b_data_out, g, grp_b(1, g)); end
            n_tests++; if (b_out_last !== (g == 2)) begin n_fail++; $display("FAIL pad_last%0d got %b exp %b", g, b_out_last, g == 2); end
        end
        @(negedge clk); #1;
        n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL pad_end got %b exp 0", b_out_valid); end
        // cfg 7 exceeds NUM_GROUP=3 and clamps to 3
        b_in_valid = 1'b1; b_data_in = vec_b(40); b_cfg = 3'd7;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            b_in_valid = 1'b0; #1;
            n_tests++; if (b_out_valid !== 1'b1 || b_out_grp !== 2'(g) || b_out_last !== (g == 2)) begin n_fail++; $display("FAIL clamp7_g%0d got vld=%b grp=%0d last=%b", g, b_out_valid, b_out_grp, b_out_last); end
        end
        @(negedge clk); #1;
        n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL clamp7_end got %b exp 0", b_out_valid); end
    endtask

    task automatic test_cfg_clamp();
        // cfg 0 -> 1 group; continuous in_valid accepts a frame every cycle
        @(negedge clk);
        a_in_valid = 1'b1; a_data_in = vec_a(10); a_cfg = 2'd0; a_out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            @(negedge clk); #1;
            n_tests++; if (a_out_valid !== 1'b1 || a_out_grp !== 1'b0 || a_out_last !== 1'b1 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL cfg0_f%0d got vld=%b grp=%b last=%b rdy=%b exp 1/0/1/1", f, a_out_valid, a_out_grp, a_out_last, a_in_ready); end
            n_tests++; if (a_data_out !== grp_a(10 + f*30, 0)) begin n_fail++; $display("FAIL cfg0_data%0d got %h exp %h", f, a_data_out, grp_a(10 + f*30, 0)); end
            a_data_in = vec_a(10 + (f+1)*30);
            a_in_valid = (f < 2);
        end
        @(negedge clk); #1;
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL cfg0_end got %b exp 0", a_out_valid); end
        // cfg 3 exceeds NUM_GROUP=2 and clamps to 2
        a_in_valid = 1'b1; a_data_in = vec_a(5); a_cfg = 2'd3;
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            a_in_valid = 1'b0; #1;
            n_tests++; if (a_out_valid !== 1'b1 || a_out_grp !== 1'(g) || a_out_last !== (g == 1)) begin n_fail++; $display("FAIL cfg3_g%0d got vld=%b grp=%b last=%b", g, a_out_valid, a_out_grp, a_out_last); end
        end
        @(negedge clk); #1;
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL cfg3_end got %b exp 0", a_out_valid); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a_in_valid = 1'b1; a_data_in = vec_a(0); a_cfg = 2'd2; a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int f, g;
            f = i / 2; g = i % 2;
            @(negedge clk); #1;
            n_tests++; if (a_out_valid !== 1'b1 || a_out_grp !== 1'(g) || a_in_ready !== (g == 1)) begin n_fail++; $display("FAIL b2b_ctl%0d got vld=%b grp=%b rdy=%b exp 1/%0d/%0d", i, a_out_valid, a_out_grp, a_in_ready, g, g == 1); end
            n_tests++; if (a_data_out !== grp_a(f*20, g)) begin n_fail++; $display("FAIL b2b_data%0d got %h exp %h", i, a_data_out, grp_a(f*20, g)); end
            a_data_in  = vec_a((f+1)*20);
            a_in_valid = (f + 1 < 4);
        end
        @(negedge clk); #1;
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b exp 0", a_out_valid); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        a_in_valid = 1'b1; a_data_in = vec_a(100); a_cfg = 2'd2; a_out_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            // a competing vector must be ignored while stalled
            a_in_valid = 1'b1; a_data_in = vec_a(50); a_out_ready = 1'b0; #1;
            n_tests++; if (a_out_grp !== 1'b0 || a_data_out !== grp_a(100, 0) || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall%0d got grp=%b data=%h rdy=%b exp 0/%h/0", s, a_out_grp, a_data_out, a_in_ready, grp_a(100, 0)); end
        end
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 1'b1; #1;
        n_tests++; if (a_out_grp !== 1'b0 || a_data_out !== grp_a(100, 0)) begin n_fail++; $display("FAIL stall_release got grp=%b data=%h exp 0/%h", a_out_grp, a_data_out, grp_a(100, 0)); end
        @(negedge clk); #1;
        n_tests++; if (a_out_grp !== 1'b1 || a_out_last !== 1'b1 || a_data_out !== grp_a(100, 1)) begin n_fail++; $display("FAIL stall_g1 got grp=%b last=%b data=%h exp 1/1/%h", a_out_grp, a_out_last, a_data_out, grp_a(100, 1)); end
        @(negedge clk); #1;
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end got %b exp 0", a_out_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_in_valid = 1'b1; a_data_in = vec_a(1); a_cfg = 2'd2; a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        a_in_valid = 1'b1; a_out_ready = 1'b0; #1;
        n_tests++; if (a_out_grp !== 1'b1 || a_out_last !== 1'b1 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_stall got grp=%b last=%b rdy=%b exp 1/1/0", a_out_grp, a_out_last, a_in_ready); end
        @(negedge clk);
        rst = 1'b1; a_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; #1;
        n_tests++; if (a_out_valid !== 1'b0 || a_data_out !== 72'd0 || a_out_grp !== 1'b0 || a_out_last !== 1'b0) begin n_fail++; $display("FAIL rmid_reset got vld=%b data=%h grp=%b last=%b exp 0/0/0/0", a_out_valid, a_data_out, a_out_grp, a_out_last); end
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b exp 1", a_in_ready); end
        a_in_valid = 1'b1; a_data_in = vec_a(30); a_cfg = 2'd1; a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0; #1;
        n_tests++; if (a_out_valid !== 1'b1 || a_data_out !== grp_a(30, 0) || a_out_last !== 1'b1) begin n_fail++; $display("FAIL rmid_new got vld=%b data=%h last=%b exp 1/%h/1", a_out_valid, a_data_out, a_out_last, grp_a(30, 0)); end
        @(negedge clk); #1;
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_end got %b exp 0", a_out_valid); end
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_data_in = '0; a_cfg = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_data_in = '0; b_cfg = '0; b_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_padding();
        test_cfg_clamp();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
